// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encodings and pointer-width helper for rr_arbiter
package arb_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority pick: first requester after ptr, as one-hot and index
module rr_pick
   import arb_pkg::*;
#(
   parameter int PORT_NUM = 4,
   parameter int PTR_W    = ptr_w(PORT_NUM)
) (
   input  logic [PORT_NUM-1:0] req,
   input  logic [PTR_W-1:0]    ptr,
   output logic [PORT_NUM-1:0] win,
   output logic [PTR_W-1:0]    idx
);

   logic             found;
   logic [PTR_W-1:0] cand;

   // Scanning ptr+1, ptr+2, ... modulo PORT_NUM is the rotate/lowest-bit/rotate-back
   // pick folded into one loop.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= PORT_NUM; i++) begin
         cand = PTR_W'((int'(ptr) + i) % PORT_NUM);
         if (!found && req[cand]) begin
            found     = 1'b1;
            win[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with single-entry output register
// Optional packet lock (last_i/last_o) enabled by defining RR_ARBITER_LOCK_EN.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PORT_NUM   = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [PORT_NUM-1:0]            req_i,
   input  logic [DATA_WIDTH*PORT_NUM-1:0] data_i,
   output logic [PORT_NUM-1:0]            ready_o,
`ifdef RR_ARBITER_LOCK_EN
   input  logic [PORT_NUM-1:0]            last_i,
   output logic                           last_o,
`endif
   output logic                           valid_o,
   output logic [DATA_WIDTH-1:0]          data_o,
   output logic [PORT_NUM-1:0]            grant_o,
   input  logic                           ready_i
);

   localparam int PTR_W = ptr_w(PORT_NUM);

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, pick_idx, sel_idx;
   logic [PORT_NUM-1:0]   pick_win, sel_win, grant_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  any_req, load;
   logic [DATA_WIDTH-1:0] port_data [PORT_NUM];

   for (genvar k = 0; k < PORT_NUM; k++) begin : g_slice
      assign port_data[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_pick #(
      .PORT_NUM (PORT_NUM),
      .PTR_W    (PTR_W)
   ) u_pick (
      .req (req_i),
      .ptr (ptr_q),
      .win (pick_win),
      .idx (pick_idx)
   );

`ifdef RR_ARBITER_LOCK_EN
   logic lock_q, last_q;

   // While locked, ptr_q still names the port that owns the open packet.
   assign sel_idx = lock_q ? ptr_q : pick_idx;
   assign sel_win = lock_q ? (PORT_NUM'(1) << ptr_q) : pick_win;
   assign any_req = lock_q ? req_i[ptr_q] : |req_i;
   assign last_o  = last_q;
`else
   assign sel_idx = pick_idx;
   assign sel_win = pick_win;
   assign any_req = |req_i;
`endif

   assign valid_o = (state_q == ST_FULL);
   assign data_o  = data_q;
   assign grant_o = grant_q;
   assign load    = any_req & (~valid_o | ready_i);
   assign ready_o = (load && !rst_i) ? sel_win : '0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (load) state_d = ST_FULL;
         ST_FULL:  if (ready_i && !load) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         ptr_q   <= PTR_W'(PORT_NUM - 1);
         data_q  <= '0;
         grant_q <= '0;
`ifdef RR_ARBITER_LOCK_EN
         lock_q  <= 1'b0;
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (load) begin
            data_q  <= port_data[sel_idx];
            grant_q <= sel_win;
            ptr_q   <= sel_idx;
`ifdef RR_ARBITER_LOCK_EN
            lock_q  <= ~last_i[sel_idx];
            last_q  <= last_i[sel_idx];
`endif
         end else if (valid_o && ready_i) begin
            grant_q <= '0;
         end
      end
   end

endmodule
